// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART receive path.
package uart_pkg;

    localparam int DEFAULT_WORD_SIZE       = 8;
    localparam int DEFAULT_SAMPLES_PER_BIT = 8;

    typedef enum logic [1:0] {
        IDLE,
        STARTING,
        RECEIVING
    } rx_state_t;

endpackage

// File: rtl/rx_bit_sampler.sv
// Oversampling counter for the UART receiver: produces the start-bit half-period
// strobe and the per-bit centre strobe from Sample_tick.
module rx_bit_sampler #(
    parameter int SAMPLES_PER_BIT = 8
) (
    input  logic Clock,
    input  logic rst,
    input  logic sample_tick,
    input  logic starting,
    input  logic receiving,
    output logic half_done,
    output logic bit_centre
);

    localparam int CW = $clog2(SAMPLES_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(SAMPLES_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(SAMPLES_PER_BIT - 1);

    logic [CW-1:0] sample_cnt;

    // Counter is held at zero whenever the receiver is idle, so every new start begins aligned.
    always_ff @(posedge Clock) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (!starting && !receiving) begin
            sample_cnt <= '0;
        end else if (sample_tick) begin
            if (starting && sample_cnt == HALF_LAST) begin
                sample_cnt <= '0;
            end else if (receiving && sample_cnt == BIT_LAST) begin
                sample_cnt <= '0;
            end else begin
                sample_cnt <= sample_cnt + CW'(1);
            end
        end
    end

    assign half_done  = sample_tick && starting  && (sample_cnt == HALF_LAST);
    assign bit_centre = sample_tick && receiving && (sample_cnt == BIT_LAST);

endmodule

// File: rtl/uart_rx_unit.sv
// UART receiver top: start detection, LSB-first assembly, stop check and host handshake.
// Optional even parity bit and Error3 output enabled by defining UART_RX_PARITY_EN.
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int WORD_SIZE       = DEFAULT_WORD_SIZE,
    parameter int SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT
) (
    input  logic                 Clock,
    input  logic                 rst,
    input  logic                 Serial_in,
    input  logic                 Sample_tick,
    input  logic                 read_not_ready_in,
    output logic [WORD_SIZE-1:0] RCV_datareg,
    output logic                 read_not_ready_out,
    output logic                 Error1,
    output logic                 Error2
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 Error3
`endif
);

`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = WORD_SIZE + 1;
`else
    localparam int FRAME_BITS = WORD_SIZE;
`endif
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [BW-1:0] WORD_LAST = BW'(WORD_SIZE);
    localparam logic [BW-1:0] STOP_IDX  = BW'(FRAME_BITS);

    rx_state_t state, state_next;

    logic [BW-1:0]        bit_cnt;
    logic [WORD_SIZE-1:0] shift_reg;
    logic                 half_done;
    logic                 bit_centre;
    logic                 enter_rx;
    logic                 data_bit;
    logic                 frame_end;
    logic                 done_pending;
    logic                 stop_seen;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 parity_acc;
`endif

    rx_bit_sampler #(
        .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
    ) u_sampler (
        .Clock      (Clock),
        .rst        (rst),
        .sample_tick(Sample_tick),
        .starting   (state == STARTING),
        .receiving  (state == RECEIVING),
        .half_done  (half_done),
        .bit_centre (bit_centre)
    );

    always_ff @(posedge Clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A high sample during STARTING wins over the half-period strobe, rejecting glitches.
    always_comb begin
        state_next = state;
        enter_rx   = 1'b0;
        data_bit   = 1'b0;
        frame_end  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (Sample_tick && !Serial_in) begin
                    state_next = STARTING;
                end
            end
            STARTING: begin
                if (Sample_tick && Serial_in) begin
                    state_next = IDLE;
                end else if (half_done) begin
                    state_next = RECEIVING;
                    enter_rx   = 1'b1;
                end
            end
            RECEIVING: begin
                if (bit_centre) begin
                    if (bit_cnt == STOP_IDX) begin
                        state_next = IDLE;
                        frame_end  = 1'b1;
                    end else if (bit_cnt < WORD_LAST) begin
                        data_bit = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else begin
                        par_bit = 1'b1;
`endif
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (rst) begin
            bit_cnt      <= '0;
            shift_reg    <= '0;
            done_pending <= 1'b0;
            stop_seen    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_acc   <= 1'b0;
`endif
        end else begin
            done_pending <= frame_end;
            if (frame_end) begin
                stop_seen <= Serial_in;
            end
            if (enter_rx) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                parity_acc <= 1'b0;
`endif
            end else if (data_bit) begin
                shift_reg <= {Serial_in, shift_reg[WORD_SIZE-1:1]};
                bit_cnt   <= bit_cnt + BW'(1);
`ifdef UART_RX_PARITY_EN
                parity_acc <= parity_acc ^ Serial_in;
            end else if (par_bit) begin
                bit_cnt    <= bit_cnt + BW'(1);
                parity_acc <= parity_acc ^ Serial_in;
`endif
            end
        end
    end

    // An ack in the completion cycle frees the buffer first, so the new word is accepted.
    always_ff @(posedge Clock) begin
        if (rst) begin
            RCV_datareg        <= '0;
            read_not_ready_out <= 1'b0;
            Error1             <= 1'b0;
            Error2             <= 1'b0;
`ifdef UART_RX_PARITY_EN
            Error3             <= 1'b0;
`endif
        end else if (done_pending) begin
            if (!read_not_ready_out || read_not_ready_in) begin
                RCV_datareg        <= shift_reg;
                read_not_ready_out <= 1'b1;
                Error1             <= read_not_ready_in ? 1'b0 : Error1;
                Error2             <= (read_not_ready_in ? 1'b0 : Error2) | ~stop_seen;
`ifdef UART_RX_PARITY_EN
                Error3             <= (read_not_ready_in ? 1'b0 : Error3) | parity_acc;
`endif
            end else begin
                Error1 <= 1'b1;
            end
        end else if (read_not_ready_in) begin
            read_not_ready_out <= 1'b0;
            Error1             <= 1'b0;
            Error2             <= 1'b0;
`ifdef UART_RX_PARITY_EN
            Error3             <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Self-checking bench for uart_rx_unit: directed frames plus randomized traffic
// checked against a transaction-level model of the receiver's host interface.
module tb_uart_rx_unit;

    localparam int WORD_SIZE = 8;
    localparam int SPB       = 8;

    logic                 Clock = 1'b0;
    logic                 rst;
    logic                 Serial_in;
    logic                 Sample_tick;
    logic                 read_not_ready_in;
    logic [WORD_SIZE-1:0] RCV_datareg;
    logic                 read_not_ready_out;
    logic                 Error1;
    logic                 Error2;
`ifdef UART_RX_PARITY_EN
    logic                 Error3;
`endif

    int checks = 0;
    int errors = 0;
    int gap_left = 2;
    bit tick_seen = 1'b0;

    logic [WORD_SIZE-1:0] exp_data;
    logic                 exp_ready;
    logic                 exp_e1;
    logic                 exp_e2;
    logic                 exp_e3;

    uart_rx_unit #(
        .WORD_SIZE      (WORD_SIZE),
        .SAMPLES_PER_BIT(SPB)
    ) dut (
        .Clock             (Clock),
        .rst               (rst),
        .Serial_in         (Serial_in),
        .Sample_tick       (Sample_tick),
        .read_not_ready_in (read_not_ready_in),
        .RCV_datareg       (RCV_datareg),
        .read_not_ready_out(read_not_ready_out),
        .Error1            (Error1),
        .Error2            (Error2)
`ifdef UART_RX_PARITY_EN
        ,
        .Error3            (Error3)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; ticks are single-cycle pulses separated by 1-3 idle cycles.
    task automatic nextCycle();
        @(posedge Clock);
        #1;
        tick_seen = Sample_tick;
        if (gap_left == 0) begin
            Sample_tick = 1'b1;
            gap_left    = $urandom_range(1, 3);
        end else begin
            Sample_tick = 1'b0;
            gap_left--;
        end
    endtask

    task automatic waitTicks(input int n);
        int got = 0;
        while (got < n) begin
            nextCycle();
            if (tick_seen) got++;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_data"},  32'(RCV_datareg),        32'(exp_data));
        checkOutput({tag, "_ready"}, 32'(read_not_ready_out), 32'(exp_ready));
        checkOutput({tag, "_err1"},  32'(Error1),             32'(exp_e1));
        checkOutput({tag, "_err2"},  32'(Error2),             32'(exp_e2));
`ifdef UART_RX_PARITY_EN
        checkOutput({tag, "_err3"},  32'(Error3),             32'(exp_e3));
`endif
    endtask

    task automatic modelReset();
        exp_data  = '0;
        exp_ready = 1'b0;
        exp_e1    = 1'b0;
        exp_e2    = 1'b0;
        exp_e3    = 1'b0;
    endtask

    // Send one full frame; each bit lasts SPB ticks, so the receiver samples the stop bit
    // on its fifth tick. Optional ack is pulsed in the cycle the frame completes.
    task automatic applyStimulus(input logic [WORD_SIZE-1:0] data, input logic stop,
                                 input logic par, input bit ack_at_done, input string tag);
        Serial_in = 1'b0;
        waitTicks(SPB);
        for (int k = 0; k < WORD_SIZE; k++) begin
            Serial_in = data[k];
            waitTicks(SPB);
        end
`ifdef UART_RX_PARITY_EN
        Serial_in = par;
        waitTicks(SPB);
`endif
        Serial_in = stop;
        waitTicks(SPB / 2);
        waitTicks(1);
        checkOutput({tag, "_latency"}, 32'(read_not_ready_out), 32'(exp_ready));
        read_not_ready_in = ack_at_done;
        nextCycle();
        read_not_ready_in = 1'b0;
        if (!exp_ready || ack_at_done) begin
            if (ack_at_done) begin
                exp_e1 = 1'b0;
                exp_e2 = 1'b0;
                exp_e3 = 1'b0;
            end
            exp_data  = data;
            exp_ready = 1'b1;
            exp_e2    = exp_e2 | ~stop;
            exp_e3    = exp_e3 | ((^data) ^ par);
        end else begin
            exp_e1 = 1'b1;
        end
        checkAll(tag);
        Serial_in = 1'b1;
        waitTicks(SPB / 2);
    endtask

    task automatic doAck(input string tag);
        read_not_ready_in = 1'b1;
        nextCycle();
        read_not_ready_in = 1'b0;
        exp_ready = 1'b0;
        exp_e1    = 1'b0;
        exp_e2    = 1'b0;
        exp_e3    = 1'b0;
        checkAll(tag);
    endtask

    initial begin
        logic [WORD_SIZE-1:0] rdata;
        logic                 rstop;
        logic                 rpar;
        bit                   rack;

        rst               = 1'b1;
        Serial_in         = 1'b1;
        Sample_tick       = 1'b0;
        read_not_ready_in = 1'b0;
        modelReset();
        repeat (3) nextCycle();
        checkAll("reset");
        rst = 1'b0;
        waitTicks(4);

        $display("[TB] frame 0xA5");
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, "a5");
        doAck("a5_ack");

        $display("[TB] start glitch then 0x5A");
        Serial_in = 1'b0;
        waitTicks(2);
        Serial_in = 1'b1;
        waitTicks(6);
        checkAll("glitch");
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, "5a");
        doAck("5a_ack");

        $display("[TB] framing error 0x3C");
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, "3c");
        doAck("3c_ack");

        $display("[TB] overrun 0x11 / 0x22");
        applyStimulus(8'h11, 1'b1, 1'b1, 1'b0, "ov11");
        applyStimulus(8'h22, 1'b1, 1'b0, 1'b0, "ov22");
        doAck("ov_ack");
        applyStimulus(8'h11, 1'b1, 1'b1, 1'b0, "sm11");
        applyStimulus(8'h22, 1'b1, 1'b0, 1'b1, "sm22");
        doAck("sm_ack");

        $display("[TB] reset mid-frame");
        applyStimulus(8'h99, 1'b0, 1'b0, 1'b0, "pre_rst");
        Serial_in = 1'b0;
        waitTicks(SPB);
        for (int k = 0; k < 4; k++) begin
            Serial_in = k[0];
            waitTicks(SPB);
        end
        Serial_in = 1'b1;
        waitTicks(2);
        rst = 1'b1;
        repeat (2) nextCycle();
        modelReset();
        checkAll("midrst");
        rst = 1'b0;
        waitTicks(SPB);
        checkAll("midrst_idle");
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0, "ff");
        doAck("ff_ack");

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity 0x07");
        applyStimulus(8'h07, 1'b1, 1'b1, 1'b0, "par_ok");
        doAck("par_ok_ack");
        applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, "par_bad");
        doAck("par_bad_ack");
`endif

        $display("[TB] random frames");
        for (int i = 0; i < 24; i++) begin
            rdata = WORD_SIZE'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 3) != 0);
            rpar  = (^rdata) ^ ($urandom_range(0, 3) == 0);
            rack  = ($urandom_range(0, 2) == 0);
            applyStimulus(rdata, rstop, rpar, rack, "rnd");
            if ($urandom_range(0, 1) == 0) doAck("rnd_ack");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
